// File: rtl/lcd_char_ctrl.sv
// HD44780-class character LCD controller for any ROWS x COLS panel, 8- or 4-bit bus.
// E strobes are timed on the system clock from a tick divider. Each frame works from a
// snapshot of the text taken at frame start, so one frame never mixes old and new text.
module lcd_char_ctrl #(
    parameter int unsigned ROWS      = 2,
    parameter int unsigned COLS      = 16,
    parameter int unsigned BUS4      = 0,
    parameter int unsigned AUTO      = 1,
    parameter int unsigned TICK_DIV  = 50,
    parameter int unsigned E_TICKS   = 1,
    parameter int unsigned CMD_TICKS = 50,
    parameter int unsigned CLR_TICKS = 2000,
    parameter int unsigned PWR_TICKS = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*COLS*8-1:0] frame_val,
    input  logic                   refresh_req,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             lcd_data,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_e
);

    if (ROWS == 0 || ROWS > 4) begin : g_bad_rows
        $fatal(1, "lcd_char_ctrl: ROWS must be 1..4");
    end
    if (COLS < 8 || COLS > 20) begin : g_bad_cols
        $fatal(1, "lcd_char_ctrl: COLS must be 8..20");
    end

    localparam int NCH = int'(ROWS * COLS);
    localparam logic [7:0] FN_SET = (BUS4 != 0) ? ((ROWS == 1) ? 8'h20 : 8'h28)
                                                : ((ROWS == 1) ? 8'h30 : 8'h38);

    typedef enum logic [2:0] {StPwr, StWake, StInit, StIdle, StLatch, StAddr, StChar} state_e;
    typedef enum logic [2:0] {WrIdle, WrSetup, WrHigh, WrHold, WrWait} wr_e;

    state_e state_q, state_d;
    wr_e    wr_q, wr_d;

    logic [31:0]            tick_cnt_q;
    logic                   tick;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            wcnt_q, wcnt_d;
    logic [2:0]             step_q, step_d;
    logic [1:0]             row_q, row_d;
    logic [4:0]             col_q, col_d;
    logic [6:0]             idx_q, idx_d;
    logic [ROWS*COLS*8-1:0] snap_q, snap_d;
    logic [7:0]             byte_q, byte_d;
    logic                   nib_q, nib_d;
    logic                   long_q, long_d;
    logic                   hi_q, hi_d;
    logic [7:0]             data_q, data_d;
    logic                   rs_q, rs_d;
    logic                   e_q, e_d;
    logic                   frame_done_q, frame_done_d;
    logic                   first_done_q, first_done_d;
    logic                   req_pend_q, req_pend_d;

    logic                   req_valid, req_rs, req_nib, wr_done;
    logic [7:0]             req_byte, char_byte;
    logic [31:0]            wait_ticks;
    int                     char_pos;

    // Free-running tick divider; tick is high for one clk on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    assign tick = (tick_cnt_q == TICK_DIV - 1);

    // Sequencer and write-engine state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StPwr;
            wr_q         <= WrIdle;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            step_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            byte_q       <= '0;
            nib_q        <= 1'b0;
            long_q       <= 1'b0;
            hi_q         <= 1'b0;
            data_q       <= '0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            frame_done_q <= 1'b0;
            first_done_q <= 1'b0;
            req_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            step_q       <= step_d;
            row_q        <= row_d;
            col_q        <= col_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            byte_q       <= byte_d;
            nib_q        <= nib_d;
            long_q       <= long_d;
            hi_q         <= hi_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            frame_done_q <= frame_done_d;
            first_done_q <= first_done_d;
            req_pend_q   <= req_pend_d;
        end
    end

    assign wait_ticks = long_q ? CLR_TICKS : CMD_TICKS;
    assign char_pos   = NCH - 1 - int'({25'd0, idx_q});
    assign char_byte  = snap_q[8*char_pos +: 8];

    // Next state: write engine (setup, E, hold, wait) and the frame sequencer feeding it.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        step_d       = step_q;
        row_d        = row_q;
        col_d        = col_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        byte_d       = byte_q;
        nib_d        = nib_q;
        long_d       = long_q;
        hi_d         = hi_q;
        data_d       = data_q;
        rs_d         = rs_q;
        e_d          = e_q;
        frame_done_d = 1'b0;
        first_done_d = first_done_q;
        req_pend_d   = req_pend_q;
        req_valid    = 1'b0;
        req_byte     = 8'h00;
        req_rs       = 1'b0;
        req_nib      = 1'b0;
        wr_done      = 1'b0;

        // Every phase lasts whole ticks; rs/data are only touched while E is low.
        unique case (wr_q)
            WrIdle: ;
            WrSetup: begin
                if (tick) begin
                    e_d    = 1'b1;
                    wcnt_d = '0;
                    wr_d   = WrHigh;
                end
            end
            WrHigh: begin
                if (tick) begin
                    if (wcnt_q == E_TICKS - 1) begin
                        e_d    = 1'b0;
                        wcnt_d = '0;
                        wr_d   = WrHold;
                    end else begin
                        wcnt_d = wcnt_q + 32'd1;
                    end
                end
            end
            WrHold: begin
                if (tick) begin
                    if (BUS4 != 0 && hi_q && !nib_q) begin
                        hi_d   = 1'b0;
                        data_d = {byte_q[3:0], 4'h0};
                        wr_d   = WrSetup;
                    end else begin
                        wcnt_d = '0;
                        wr_d   = WrWait;
                    end
                end
            end
            WrWait: begin
                if (tick) begin
                    if (wcnt_q == wait_ticks - 1) begin
                        wr_done = 1'b1;
                        wr_d    = WrIdle;
                    end else begin
                        wcnt_d = wcnt_q + 32'd1;
                    end
                end
            end
            default: wr_d = WrIdle;
        endcase

        unique case (state_q)
            StPwr: begin
                if (tick) begin
                    if (cnt_q == PWR_TICKS - 1) begin
                        step_d  = '0;
                        state_d = (BUS4 != 0) ? StWake : StInit;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            StWake: begin
                req_valid = 1'b1;
                req_nib   = 1'b1;
                req_byte  = (step_q < 3'd3) ? 8'h30 : 8'h20;
                if (wr_done) begin
                    if (step_q == 3'd3) begin
                        step_d  = '0;
                        state_d = StInit;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            StInit: begin
                req_valid = 1'b1;
                unique case (step_q)
                    3'd0:    req_byte = FN_SET;
                    3'd1:    req_byte = 8'h08;
                    3'd2:    req_byte = 8'h01;
                    3'd3:    req_byte = 8'h06;
                    default: req_byte = 8'h0C;
                endcase
                if (wr_done) begin
                    if (step_q == 3'd4) begin
                        state_d = StIdle;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            StIdle: begin
                if (AUTO != 0 || refresh_req || req_pend_q) begin
                    req_pend_d = 1'b0;
                    state_d    = StLatch;
                end
            end
            StLatch: begin
                snap_d  = frame_val;
                row_d   = '0;
                col_d   = '0;
                idx_d   = '0;
                state_d = StAddr;
            end
            StAddr: begin
                req_valid = 1'b1;
                req_byte  = 8'h80 | (row_q[0] ? 8'h40 : 8'h00) | (row_q[1] ? 8'(COLS) : 8'h00);
                if (wr_done) begin
                    state_d = StChar;
                end
            end
            StChar: begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_byte  = char_byte;
                if (wr_done) begin
                    idx_d = idx_q + 7'd1;
                    if (col_q == 5'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == 2'(ROWS - 1)) begin
                            frame_done_d = 1'b1;
                            first_done_d = 1'b1;
                            state_d      = StIdle;
                        end else begin
                            row_d   = row_q + 2'd1;
                            state_d = StAddr;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            default: state_d = StPwr;
        endcase

        // A request landing in the very clk that IDLE is entered must not be lost.
        if (AUTO == 0 && state_q != StIdle && state_d == StIdle && refresh_req) begin
            req_pend_d = 1'b1;
        end

        // Launch a write on a tick so the setup phase is one full tick long.
        if (req_valid && wr_q == WrIdle && tick) begin
            byte_d = req_byte;
            rs_d   = req_rs;
            nib_d  = req_nib;
            long_d = (req_byte == 8'h01) && !req_rs;
            hi_d   = 1'b1;
            data_d = (BUS4 != 0) ? {req_byte[7:4], 4'h0} : req_byte;
            wcnt_d = '0;
            wr_d   = WrSetup;
        end
    end

    assign busy       = !(state_q == StIdle && AUTO == 0 && first_done_q);
    assign frame_done = frame_done_q;
    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = e_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: three instances (8-bit 16x2 auto, 4-bit 16x2 auto,
// 8-bit 4x20 on-request). Every E rising edge is logged with {rs, data} and its cycle.
module tb_lcd_char_ctrl;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   rel;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 8-bit, 16x2, free-running refresh
    logic         rst_a, req_a, busy_a, fd_a, rs_a, rw_a, e_a;
    logic [255:0] frame_a;
    logic [7:0]   data_a;
    // Instance B: 4-bit, 16x2
    logic         rst_b, req_b, busy_b, fd_b, rs_b, rw_b, e_b;
    logic [255:0] frame_b;
    logic [7:0]   data_b;
    // Instance C: 8-bit, 4x20, refresh on request
    logic         rst_c, req_c, busy_c, fd_c, rs_c, rw_c, e_c;
    logic [639:0] frame_c;
    logic [7:0]   data_c;

    lcd_char_ctrl #(.ROWS(2), .COLS(16), .BUS4(0), .AUTO(1), .TICK_DIV(2), .E_TICKS(1),
                    .CMD_TICKS(2), .CLR_TICKS(20), .PWR_TICKS(10)) dut_a (
        .clk(clk), .rst(rst_a), .frame_val(frame_a), .refresh_req(req_a), .busy(busy_a),
        .frame_done(fd_a), .lcd_data(data_a), .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_e(e_a)
    );

    lcd_char_ctrl #(.ROWS(2), .COLS(16), .BUS4(1), .AUTO(1), .TICK_DIV(2), .E_TICKS(1),
                    .CMD_TICKS(2), .CLR_TICKS(20), .PWR_TICKS(10)) dut_b (
        .clk(clk), .rst(rst_b), .frame_val(frame_b), .refresh_req(req_b), .busy(busy_b),
        .frame_done(fd_b), .lcd_data(data_b), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_e(e_b)
    );

    lcd_char_ctrl #(.ROWS(4), .COLS(20), .BUS4(0), .AUTO(0), .TICK_DIV(2), .E_TICKS(1),
                    .CMD_TICKS(2), .CLR_TICKS(20), .PWR_TICKS(10)) dut_c (
        .clk(clk), .rst(rst_c), .frame_val(frame_c), .refresh_req(req_c), .busy(busy_c),
        .frame_done(fd_c), .lcd_data(data_c), .lcd_rs(rs_c), .lcd_rw(rw_c), .lcd_e(e_c)
    );

    // Bus loggers
    logic [8:0] q_a[$], q_b[$], q_c[$];
    int         t_a[$];
    logic       ep_a = 1'b0, ep_b = 1'b0, ep_c = 1'b0;
    logic [8:0] last_a = '0;
    int         chg_a = 0, fdn_a = 0, fdn_c = 0;
    logic       lowbad_b = 1'b0;

    always @(negedge clk) begin
        if (e_a && !ep_a) begin
            q_a.push_back({rs_a, data_a});
            t_a.push_back(cyc);
        end
        if (e_a && ep_a && ({rs_a, data_a} != last_a)) chg_a <= chg_a + 1;
        last_a <= {rs_a, data_a};
        ep_a   <= e_a;
        if (fd_a) fdn_a <= fdn_a + 1;
    end

    always @(negedge clk) begin
        if (e_b && !ep_b) q_b.push_back({rs_b, data_b});
        if (data_b[3:0] != 4'h0) lowbad_b <= 1'b1;
        ep_b <= e_b;
    end

    always @(negedge clk) begin
        if (e_c && !ep_c) q_c.push_back({rs_c, data_c});
        ep_c <= e_c;
        if (fd_c) fdn_c <= fdn_c + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bus word for position i (0..33) of a 16x2 frame of text s
    function automatic logic [8:0] frame_word(input int i, input string s);
        if (i == 0) return 9'h080;
        if (i == 17) return 9'h0C0;
        if (i < 17) return {1'b1, s[i-1]};
        return {1'b1, s[i-2]};
    endfunction

    string      s_old = "ABCDEFGHIJKLMNOP0123456789abcdef";
    string      s_new = "abcdefghijklmnopQRSTUVWXYZ012345";
    logic [8:0] init8 [5] = '{9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
    logic [8:0] exp_b [18] = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h020, 9'h080, 9'h000,
                               9'h080, 9'h000, 9'h010, 9'h000, 9'h060, 9'h000, 9'h0C0,
                               9'h080, 9'h000, 9'h140, 9'h110};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        frame_a = "ABCDEFGHIJKLMNOP0123456789abcdef";
        frame_b = "ABCDEFGHIJKLMNOP0123456789abcdef";
        for (int k = 0; k < 80; k++) frame_c[(79-k)*8 +: 8] = 8'(32 + k);
        #12;

        // Reset state
        chk("rst_e", e_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_rs", rs_a, 0);
        chk("rst_rw", rw_a, 0);
        chk("rst_busy", busy_a, 1);
        chk("rst_frame_done", fd_a, 0);

        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        rel = cyc;

        // T1: power-up wait then init sequence
        n = 0;
        while (q_a.size() < 5 && n < 2000) begin @(posedge clk); n++; end
        chk("a_init_seen", q_a.size() >= 5, 1);
        chk("a_pwr_wait_min", (t_a[0] - rel) >= 20, 1);
        chk("a_pwr_wait_max", (t_a[0] - rel) <= 28, 1);
        for (int i = 0; i < 5; i++) chk("a_init_byte", q_a[i], init8[i]);
        chk("a_cmd_gap", t_a[1] - t_a[0], 12);
        chk("a_clr_gap", (t_a[3] - t_a[2]) >= 40, 1);

        // T2: first frame content and a single frame_done
        n = 0;
        while (fdn_a < 1 && n < 3000) begin @(posedge clk); n++; end
        chk("a_frame1_done", fdn_a, 1);
        chk("a_frame1_len", q_a.size(), 39);
        for (int i = 0; i < 34; i++) chk("a_frame1_word", q_a[5+i], frame_word(i, s_old));

        // T5: change text in the middle of frame 2
        n = 0;
        while (q_a.size() < 49 && n < 3000) begin @(posedge clk); n++; end
        chk("a_frame2_started", q_a.size() >= 49, 1);
        frame_a = "abcdefghijklmnopQRSTUVWXYZ012345";
        n = 0;
        while (fdn_a < 3 && n < 3000) begin @(posedge clk); n++; end
        chk("a_frame3_done", fdn_a, 3);
        for (int i = 0; i < 34; i++) chk("a_frame2_old", q_a[39+i], frame_word(i, s_old));
        for (int i = 0; i < 34; i++) chk("a_frame3_new", q_a[73+i], frame_word(i, s_new));
        chk("a_stable_while_e", chg_a, 0);

        // T6: reset while E is high
        n = 0;
        while (!e_a && n < 200) begin @(posedge clk); n++; end
        chk("a_e_high_seen", e_a, 1);
        #1 rst_a = 1'b1;
        #1;
        chk("a_rst_drops_e", e_a, 0);
        chk("a_rst_busy", busy_a, 1);
        chk("a_rst_data", data_a, 0);
        @(negedge clk);
        rst_a = 1'b0;
        rel = cyc;
        q_a.delete();
        t_a.delete();
        n = 0;
        while (q_a.size() < 5 && n < 2000) begin @(posedge clk); n++; end
        chk("a_reinit_seen", q_a.size() >= 5, 1);
        chk("a_repwr_wait_min", (t_a[0] - rel) >= 20, 1);
        chk("a_repwr_wait_max", (t_a[0] - rel) <= 28, 1);
        for (int i = 0; i < 5; i++) chk("a_reinit_byte", q_a[i], init8[i]);

        // T3: 4-bit wake, init and first char
        n = 0;
        while (q_b.size() < 18 && n < 3000) begin @(posedge clk); n++; end
        chk("b_seq_seen", q_b.size() >= 18, 1);
        for (int i = 0; i < 18; i++) chk("b_nibble", q_b[i], exp_b[i]);
        chk("b_low_nibble_zero", lowbad_b, 0);

        // T4: 4x20 on request
        chk("c_no_auto_frame", q_c.size(), 5);
        chk("c_busy_before_first", busy_c, 1);
        for (int i = 0; i < 5; i++) chk("c_init_byte", q_c[i], init8[i]);
        @(negedge clk); req_c = 1'b1;
        @(negedge clk); req_c = 1'b0;
        n = 0;
        while (q_c.size() < 20 && n < 3000) begin @(posedge clk); n++; end
        @(negedge clk); req_c = 1'b1;
        @(negedge clk); req_c = 1'b0;
        n = 0;
        while (fdn_c < 1 && n < 5000) begin @(posedge clk); n++; end
        chk("c_frame_done", fdn_c, 1);
        repeat (2) @(negedge clk);
        chk("c_busy_after_frame", busy_c, 0);
        chk("c_addr_row0", q_c[5], 9'h080);
        chk("c_addr_row1", q_c[26], 9'h0C0);
        chk("c_addr_row2", q_c[47], 9'h094);
        chk("c_addr_row3", q_c[68], 9'h0D4);
        chk("c_char_r0c0", q_c[6], 9'h120);
        chk("c_char_r1c0", q_c[27], 9'h134);
        chk("c_char_r3c19", q_c[88], 9'h16F);
        repeat (300) @(posedge clk);
        chk("c_no_extra_writes", q_c.size(), 89);
        chk("c_no_extra_frame", fdn_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
